// File: rtl/t_spi_rx.sv
// ============================================================================
// Module  : t_spi_rx
// Brief   : SPI (CPOL=1, CPHA=1) receive port with valid/ready word output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module t_spi_rx #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_cs_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic                  overrun_o,
    output logic                  frame_err_o
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_clk_pipe;
    logic [SYNC_STAGES-1:0] r_cs_pipe;
    logic [SYNC_STAGES-1:0] r_data_pipe;
    logic                   r_clk_prev;
    logic                   r_cs_prev;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0]  r_shift;

    logic                   w_clk_sync;
    logic                   w_cs_sync;
    logic                   w_data_sync;
    logic                   w_rise;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_sample;
    logic                   w_complete;
    logic [DATA_WIDTH-1:0]  w_word;

    // Equal-depth synchronizers keep data, clock and select mutually aligned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clk_pipe  <= '1;
            r_cs_pipe   <= '0;
            r_data_pipe <= '0;
            r_clk_prev  <= 1'b1;
            r_cs_prev   <= 1'b0;
        end else begin
            r_clk_pipe[0]  <= spi_clk_i;
            r_cs_pipe[0]   <= spi_cs_i;
            r_data_pipe[0] <= spi_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_clk_pipe[i]  <= r_clk_pipe[i-1];
                r_cs_pipe[i]   <= r_cs_pipe[i-1];
                r_data_pipe[i] <= r_data_pipe[i-1];
            end
            r_clk_prev <= w_clk_sync;
            r_cs_prev  <= w_cs_sync;
        end
    end

    assign w_clk_sync  = r_clk_pipe[SYNC_STAGES-1];
    assign w_cs_sync   = r_cs_pipe[SYNC_STAGES-1];
    assign w_data_sync = r_data_pipe[SYNC_STAGES-1];

    assign w_rise     = ~r_clk_prev & w_clk_sync;
    assign w_cs_fall  =  r_cs_prev  & ~w_cs_sync;
    assign w_cs_rise  = ~r_cs_prev  & w_cs_sync;

    assign w_sample   = (r_state == ST_ACTIVE) && w_rise && !w_cs_sync;
    assign w_complete = w_sample && (r_bit_cnt == LAST_BIT);
    assign w_word     = {r_shift[DATA_WIDTH-2:0], w_data_sync};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            rdata_o     <= '0;
            rvalid_o    <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;

            if (rvalid_o && rready_i) begin
                rvalid_o <= 1'b0;
            end

            // A word completing while the slot is being drained replaces it.
            if (w_complete) begin
                if (!rvalid_o || rready_i) begin
                    rdata_o  <= w_word;
                    rvalid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    if (w_cs_fall) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                        if (r_bit_cnt != '0) begin
                            frame_err_o <= 1'b1;
                        end
                    end else if (w_sample) begin
                        r_shift   <= w_word;
                        r_bit_cnt <= w_complete ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_t_spi_rx.sv
// ============================================================================
// Module  : tb_t_spi_rx
// Brief   : Self-checking bench for t_spi_rx (vector table + word scoreboard).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_t_spi_rx;

    localparam int DW   = 32;
    localparam int SYNC = 2;
    localparam int NV   = 7;

    logic          clk;
    logic          rst;
    logic          spi_d;
    logic          spi_clk;
    logic          spi_cs;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          overrun;
    logic          frame_err;

    t_spi_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .spi_i       (spi_d),
        .spi_clk_i   (spi_clk),
        .spi_cs_i    (spi_cs),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid),
        .rready_i    (rready),
        .overrun_o   (overrun),
        .frame_err_o (frame_err)
    );

    typedef struct {
        logic [63:0] bits;
        int          nbits;
        int          exp_ferr;
    } vec_t;

    vec_t          vecs [NV];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_mem [64];
    int            got_wr  = 0;
    int            got_rd  = 0;
    int            ovr_cnt = 0;
    int            ferr_cnt = 0;
    int            checks   = 0;
    int            failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: records every consumed word and every error pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid && rready && got_wr < 64) begin
                got_mem[got_wr] <= rdata;
                got_wr          <= got_wr + 1;
            end
            if (overrun)   ovr_cnt  <= ovr_cnt + 1;
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        spi_clk = 1'b0;
        spi_d   = b;
        tick();
        spi_clk = 1'b1;
        tick();
    endtask

    task automatic send_frame(input logic [63:0] bits, input int nbits);
        spi_cs = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < nbits; k++) send_bit(bits[63-k]);
        tick();
        spi_cs = 1'b1;
        repeat (4) tick();
    endtask

    task automatic drain(input string name);
        while (got_rd < got_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s unexpected word actual=%h expected=none", name, got_mem[got_rd]);
            end else begin
                check(name, got_mem[got_rd], exp_q.pop_front());
            end
            got_rd++;
        end
        while (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s missing word actual=none expected=%h", name, exp_q.pop_front());
        end
    endtask

    initial begin
        int o0;
        int f0;
        int lat;

        vecs[0] = '{64'hA5C30F96_00000000, 32, 0};
        vecs[1] = '{64'h12345678_00000000, 32, 0};
        vecs[2] = '{64'hDEADBEEF_00000000, 32, 0};
        vecs[3] = '{64'hFFC00000_00000000, 10, 1};
        vecs[4] = '{64'h0000FFFF_00000000, 32, 0};
        vecs[5] = '{64'hCAFEF00D_0BADC0DE, 64, 0};
        vecs[6] = '{64'h5A5A5A5A_80000000, 33, 1};

        rst = 1'b1; spi_d = 1'b0; spi_clk = 1'b1; spi_cs = 1'b1; rready = 1'b0;
        repeat (3) tick();
        check("rst_rvalid",  32'(rvalid), 32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ferr",    32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // Single frame held unconsumed: latency, stability, then handshake.
        f0 = ferr_cnt;
        exp_q.push_back(32'hA5C30F96);
        spi_cs = 1'b0;
        repeat (2) tick();
        for (int k = 31; k > 0; k--) send_bit(vecs[0].bits[32+k]);
        spi_clk = 1'b0;
        spi_d   = vecs[0].bits[32];
        tick();
        spi_clk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (rvalid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'(SYNC + 1));
        tick();
        spi_cs = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_rvalid", 32'(rvalid), 32'd1);
            check("hold_rdata",  rdata, 32'hA5C30F96);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("consumed_rvalid", 32'(rvalid), 32'd0);
        tick();
        check("hold_ferr", 32'(ferr_cnt - f0), 32'd0);
        drain("hold_word");

        // Two frames without a consumer: second word is dropped.
        o0 = ovr_cnt;
        exp_q.push_back(32'h12345678);
        send_frame(64'h12345678_00000000, 32);
        send_frame(64'hDEADBEEF_00000000, 32);
        repeat (4) tick();
        check("ovr_count",  32'(ovr_cnt - o0), 32'd1);
        check("ovr_rvalid", 32'(rvalid), 32'd1);
        check("ovr_rdata",  rdata, 32'h12345678);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        tick();
        drain("ovr_word");

        // Vector table, consumer always ready.
        rready = 1'b1;
        for (int v = 0; v < NV; v++) begin
            o0 = ovr_cnt;
            f0 = ferr_cnt;
            for (int w = 0; w < vecs[v].nbits / 32; w++) exp_q.push_back(vecs[v].bits[63-32*w -: 32]);
            send_frame(vecs[v].bits, vecs[v].nbits);
            repeat (4) tick();
            drain("vec_word");
            check("vec_ferr",   32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
            check("vec_ovr",    32'(ovr_cnt - o0), 32'd0);
            check("vec_rvalid", 32'(rvalid), 32'd0);
        end

        // Reset mid-frame while cs stays low; the tail must be ignored.
        f0 = ferr_cnt;
        spi_cs = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 16; k++) send_bit(k[0]);
        rst = 1'b1;
        repeat (2) tick();
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_rdata",  rdata, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) send_bit(~k[0]);
        tick();
        spi_cs = 1'b1;
        repeat (6) tick();
        check("midrst_ferr", 32'(ferr_cnt - f0), 32'd0);
        drain("midrst_none");
        exp_q.push_back(32'h80000001);
        send_frame(64'h80000001_00000000, 32);
        repeat (4) tick();
        drain("after_rst_word");
        check("after_rst_ferr", 32'(ferr_cnt - f0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/t_spi_rx.md
Name: t_spi_rx

Overview:
- Receive side of the FPGA test SPI link. Captures serial frames from an SPI initiator clocked by the same system clock.
- SPI format: CPOL=1, CPHA=1. Clock idles high, data changes on the falling edge, data is sampled on the rising edge, MSB first, chip select active low.
- Assembles DATA_WIDTH-bit words and presents them on a valid/ready output. Used in FPGA loopback benches to check what the SoC or test driver shifted out.

Parameters:
- DATA_WIDTH, 32, bits per word; must be ≥2.
- SYNC_STAGES, 2, synchronizer flops on each SPI input; must be ≥1.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  synchronous reset, active high.
- spi_i  in  1  serial data from the initiator (MOSI).
- spi_clk_i  in  1  SPI clock; idles high.
- spi_cs_i  in  1  chip select, active low.
- rdata_o  out  DATA_WIDTH  received word; bit DATA_WIDTH-1 is the first bit received.
- rvalid_o  out  1  rdata_o holds an unconsumed word.
- rready_i  in  1  consumer accepts rdata_o while rvalid_o=1.
- overrun_o  out  1  one-cycle pulse: a completed word was dropped.
- frame_err_o  out  1  one-cycle pulse: frame ended with a partial word.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Synchronizers: spi_i, spi_clk_i and spi_cs_i each pass through SYNC_STAGES flops of equal depth, so their relative alignment is preserved.
  - Reset values: clk stages 1, cs stages 0, data stages 0.
  - One more registered copy of clk_sync and cs_sync is kept for edge detection.
- Edges:
  - rise = clk_prev==0 && clk_sync==1.
  - cs_fall = cs_prev==1 && cs_sync==0.
  - cs_rise = cs_prev==0 && cs_sync==1.
- Input timing requirement: spi_clk_i high and low phases each last ≥1 clk_i cycle, and spi_i is stable from the falling edge until after the next rising edge.
- FSM states: IDLE, ACTIVE.
  - IDLE: bit_cnt=0, shifting disabled. cs_fall -> ACTIVE.
  - Because cs stages reset to 0, a frame already in progress at reset release is ignored. The block only enters ACTIVE after it sees cs high, then low.
  - ACTIVE, rise with cs_sync==0:
    - shift_reg <= {shift_reg[DATA_WIDTH-2:0], data_sync}.
    - bit_cnt increments.
    - On the DATA_WIDTH-th bit the word completes (see Output) and bit_cnt wraps to 0 in the same cycle, while staying in ACTIVE.
    - Further bits in the same frame start a new word (continuous streaming).
  - ACTIVE, cs_rise -> IDLE. If bit_cnt != 0, pulse frame_err_o for one cycle and discard the partial word. If bit_cnt==0, no error.
  - If rise and cs_rise occur in the same cycle, the rise is ignored, because sampling requires cs_sync==0.
- Latency: a word completes on the cycle its last rise is detected. rvalid_o asserts the next cycle, which is SYNC_STAGES+1 clk_i cycles after the final spi_clk_i rising edge at the pin.
- Output handshake:
  - rvalid_o=1 holds rdata_o stable until a cycle with rready_i=1.
  - In that cycle the word is consumed: rvalid_o drops next cycle unless a new word completes in the same cycle.
  - Completion when rvalid_o=0: load rdata_o, set rvalid_o.
  - Completion when rvalid_o=1 && rready_i=1: load the new word, rvalid_o stays 1, no overrun.
  - Completion when rvalid_o=1 && rready_i=0: new word dropped, rdata_o unchanged, overrun_o pulses one cycle.
- Reset (any time, including mid-frame), all effective on the next edge:
  - rdata_o=0, rvalid_o=0, overrun_o=0, frame_err_o=0.
  - State IDLE, bit_cnt=0, shift_reg=0.
  - Synchronizers at the reset values above.
- rready_i with rvalid_o=0 has no effect.

Test Plan:
- Send a 32-bit frame 0xA5C30F96 (cs low, 32 clock pulses of 1 clk_i cycle low / 1 cycle high, cs high), rready_i=0 -> rvalid_o=1, rdata_o=0xA5C30F96, held stable; one cycle of rready_i=1 -> rvalid_o=0 next cycle; no error pulses.
- Two frames 0x12345678 then 0xDEADBEEF, rready_i held 0 -> rdata_o=0x12345678 retained, exactly one overrun_o pulse at the second completion.
- Same two frames with rready_i tied 1 -> each word is visible for one cycle with rvalid_o=1; the consumer sees 0x12345678 then 0xDEADBEEF; overrun_o never pulses.
- cs low, 10 rising edges, then cs high -> one frame_err_o pulse, rvalid_o stays 0. A following full frame 0x0000FFFF is received correctly, showing bit_cnt restarted at 0.
- Assert rst_i after 16 bits of a frame while cs stays low, release, then finish the frame -> no rvalid_o and no frame_err_o. The next complete frame 0x80000001 is received correctly.
- cs held low for 64 rising edges carrying 0xCAFEF00D then 0x0BADC0DE, rready_i=1 -> two words delivered in order, no frame_err_o at cs_rise.
